// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: issues instruction-bus requests, buffers a response while
// decode stalls, and steers the PC register on sequential flow, redirects and flushes.
module pc_fetch_ctrl #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        flush_valid,
    input  logic [63:0] flush_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic [63:0] pc_nxt,
    output logic [1:0]  PCWrite,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] PCW_NEXT = 2'b00;
    localparam logic [1:0] PCW_INIT = 2'b01;
    localparam logic [1:0] PCW_HOLD = 2'b10;

    state_t      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [63:0] pend_pc_q, pend_pc_d;
    logic [63:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;

    // A flush outranks a same-cycle redirect; targets are forced to word alignment.
    logic        redir;
    logic [63:0] redir_raw;
    logic [63:0] redir_tgt;
    logic [63:0] pc_seq;

    assign redir     = flush_valid | redirect_valid;
    assign redir_raw = flush_valid ? flush_pc : redirect_pc;
    assign redir_tgt = redir_raw & ~64'h3;
    assign pc_seq    = pc + 64'(PC_STEP);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        ireq_valid   = 1'b0;
        ireq_addr    = pc;
        PCWrite      = PCW_HOLD;
        pc_nxt       = pc;
        if_valid     = 1'b0;
        if_pc        = 64'd0;
        if_instr     = 32'd0;

        unique case (state_q)
            BOOT: begin
                PCWrite      = PCW_INIT;
                pend_valid_d = 1'b0;
                state_d      = FETCH;
            end

            FETCH: begin
                ireq_valid = 1'b1;
                if (!iresp_data_ok) begin
                    if (redir) begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = redir_tgt;
                    end
                end else if (redir || pend_valid_q) begin
                    // Response belongs to the wrong path: drop it and steer to the target.
                    PCWrite      = PCW_NEXT;
                    pc_nxt       = redir ? redir_tgt : pend_pc_q;
                    pend_valid_d = 1'b0;
                end else begin
                    if_valid = 1'b1;
                    if_pc    = pc;
                    if_instr = iresp_data;
                    if (stall) begin
                        buf_pc_d    = pc;
                        buf_instr_d = iresp_data;
                        state_d     = HOLD;
                    end else begin
                        PCWrite = PCW_NEXT;
                        pc_nxt  = pc_seq;
                    end
                end
            end

            HOLD: begin
                if (redir) begin
                    PCWrite = PCW_NEXT;
                    pc_nxt  = redir_tgt;
                    state_d = FETCH;
                end else begin
                    if_valid = 1'b1;
                    if_pc    = buf_pc_q;
                    if_instr = buf_instr_q;
                    if (!stall) begin
                        PCWrite = PCW_NEXT;
                        pc_nxt  = pc_seq;
                        state_d = FETCH;
                    end
                end
            end

            default: state_d = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 64'd0;
            buf_pc_q     <= 64'd0;
            buf_instr_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Table-driven bench for pc_fetch_ctrl: each row drives one cycle of inputs and queues the
// expected outputs, which are popped and compared at the following falling edge.
module tb_pc_fetch_ctrl;

    localparam logic [63:0] PCINIT = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc = PCINIT;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        flush_valid = 1'b0;
    logic [63:0] flush_pc = 64'd0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'd0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic [63:0] pc_nxt;
    logic [1:0]  PCWrite;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;

    int n_checks = 0;
    int n_pass   = 0;

    pc_fetch_ctrl #(.PC_STEP(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .pc_nxt        (pc_nxt),
        .PCWrite       (PCWrite),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [63:0] pc;
        logic        stall;
        logic        rv;
        logic [63:0] rpc;
        logic        fv;
        logic [63:0] fpc;
        logic        ok;
        logic [31:0] data;
        logic        e_ireq;
        logic [1:0]  e_pcw;
        logic [63:0] e_nxt;
        logic        e_ifv;
        logic [63:0] e_ifpc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic rst, input logic [63:0] p, input logic st,
                                input logic rv, input logic [63:0] rpc,
                                input logic fv, input logic [63:0] fpc,
                                input logic ok, input logic [31:0] data,
                                input logic e_ireq, input logic [1:0] e_pcw,
                                input logic [63:0] e_nxt, input logic e_ifv,
                                input logic [63:0] e_ifpc, input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst;  v.pc = p;  v.stall = st;
        v.rv = rv;    v.rpc = rpc;
        v.fv = fv;    v.fpc = fpc;
        v.ok = ok;    v.data = data;
        v.e_ireq = e_ireq;  v.e_pcw = e_pcw;  v.e_nxt = e_nxt;
        v.e_ifv = e_ifv;    v.e_ifpc = e_ifpc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input vec_t v);
        reset          = v.rst;
        pc             = v.pc;
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        flush_valid    = v.fv;
        flush_pc       = v.fpc;
        iresp_data_ok  = v.ok;
        iresp_data     = v.data;
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, "_ireq_valid"}, 64'(ireq_valid), 64'(e.e_ireq));
        if (e.e_ireq)
            check({tag, "_ireq_addr"}, ireq_addr, e.pc);
        check({tag, "_PCWrite"},  64'(PCWrite),  64'(e.e_pcw));
        check({tag, "_pc_nxt"},   pc_nxt,        e.e_nxt);
        check({tag, "_if_valid"}, 64'(if_valid), 64'(e.e_ifv));
        check({tag, "_if_pc"},    if_pc,         e.e_ifpc);
        check({tag, "_if_instr"}, 64'(if_instr), 64'(e.e_instr));
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string phase);
        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("%s%0d", phase, i));
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, one ignored-redirect BOOT cycle, two-cycle miss, then a hit.
        vecs.push_back(mk(0, PCINIT, 0, 0, 0, 0, 0, 0, 0,                     0, 2'b01, PCINIT, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT, 0, 1, 64'h123, 0, 0, 0, 0,               0, 2'b01, PCINIT, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT, 0, 0, 0, 0, 0, 0, 0,                     1, 2'b10, PCINIT, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT, 0, 0, 0, 0, 0, 0, 0,                     1, 2'b10, PCINIT, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT, 0, 0, 0, 0, 0, 1, 32'h13,                1, 2'b00, PCINIT + 4, 1, PCINIT, 32'h13));
        // Stall on a hit, three HOLD cycles with garbage on the bus, then release.
        vecs.push_back(mk(1, PCINIT + 4, 1, 0, 0, 0, 0, 1, 32'h00a00093,      1, 2'b10, PCINIT + 4, 1, PCINIT + 4, 32'h00a00093));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, PCINIT + 4, 1, 0, 0, 0, 0, 1, 32'hdeadbeef,  0, 2'b10, PCINIT + 4, 1, PCINIT + 4, 32'h00a00093));
        vecs.push_back(mk(1, PCINIT + 4, 0, 0, 0, 0, 0, 0, 0,                 0, 2'b00, PCINIT + 8, 1, PCINIT + 4, 32'h00a00093));
        // Redirect during a miss becomes pending; the late response is discarded despite stall.
        vecs.push_back(mk(1, PCINIT + 8, 0, 1, 64'h80001002, 0, 0, 0, 0,      1, 2'b10, PCINIT + 8, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT + 8, 0, 0, 0, 0, 0, 0, 0,                 1, 2'b10, PCINIT + 8, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT + 8, 1, 0, 0, 0, 0, 1, 32'h11111111,      1, 2'b00, 64'h80001000, 0, 0, 0));
        vecs.push_back(mk(1, 64'h80001000, 0, 0, 0, 0, 0, 1, 32'h22,          1, 2'b00, 64'h80001004, 1, 64'h80001000, 32'h22));
        // Flush and redirect together with a hit: flush wins.
        vecs.push_back(mk(1, 64'h80001004, 0, 1, 64'h80000200, 1, 64'h80000100, 1, 32'h33,
                                                                              1, 2'b00, 64'h80000100, 0, 0, 0));
        // Pending target overwritten by later redirect, then by flush.
        vecs.push_back(mk(1, 64'h80000100, 0, 1, 64'h80000300, 0, 0, 0, 0,    1, 2'b10, 64'h80000100, 0, 0, 0));
        vecs.push_back(mk(1, 64'h80000100, 0, 1, 64'h80000400, 0, 0, 0, 0,    1, 2'b10, 64'h80000100, 0, 0, 0));
        vecs.push_back(mk(1, 64'h80000100, 0, 1, 64'h80000600, 1, 64'h80000500, 0, 0,
                                                                              1, 2'b10, 64'h80000100, 0, 0, 0));
        vecs.push_back(mk(1, 64'h80000100, 0, 0, 0, 0, 0, 1, 32'h44,          1, 2'b00, 64'h80000500, 0, 0, 0));
        // Same-cycle redirect beats a pending one; low bits cleared.
        vecs.push_back(mk(1, 64'h80000500, 0, 1, 64'h80000700, 0, 0, 0, 0,    1, 2'b10, 64'h80000500, 0, 0, 0));
        vecs.push_back(mk(1, 64'h80000500, 0, 1, 64'h80000806, 0, 0, 1, 32'h55,
                                                                              1, 2'b00, 64'h80000804, 0, 0, 0));
        // Redirect while holding drops the buffer.
        vecs.push_back(mk(1, 64'h80000804, 1, 0, 0, 0, 0, 1, 32'h66,          1, 2'b10, 64'h80000804, 1, 64'h80000804, 32'h66));
        vecs.push_back(mk(1, 64'h80000804, 1, 1, 64'h80000040, 0, 0, 0, 0,    0, 2'b00, 64'h80000040, 0, 0, 0));
        vecs.push_back(mk(1, 64'h80000040, 0, 0, 0, 0, 0, 0, 0,                1, 2'b10, 64'h80000040, 0, 0, 0));
        // Sequential increment wraps at 2^64, then enter HOLD for the reset test.
        vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 1, 32'h77,
                                                                              1, 2'b00, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h77));
        vecs.push_back(mk(1, 64'd0, 1, 0, 0, 0, 0, 1, 32'h88,                 1, 2'b10, 64'd0, 1, 64'd0, 32'h88));

        @(posedge clk);
        #1;
        run_table("a");

        // Asynchronous reset in HOLD: buffer abandoned before any clock edge.
        drive(mk(1, PCINIT, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("hold_pre_if_valid", 64'(if_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("hold_rst_if_valid", 64'(if_valid), 64'd0);
        check("hold_rst_if_instr", 64'(if_instr), 64'd0);
        check("hold_rst_PCWrite",  64'(PCWrite),  64'd1);
        @(posedge clk);
        #1;

        vecs.push_back(mk(0, PCINIT, 0, 0, 0, 0, 0, 0, 0,                     0, 2'b01, PCINIT, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT, 0, 0, 0, 0, 0, 1, 32'haa,                0, 2'b01, PCINIT, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT, 0, 0, 0, 0, 0, 0, 0,                     1, 2'b10, PCINIT, 0, 0, 0));
        run_table("b");

        // Asynchronous reset in FETCH: request withdrawn before the next edge.
        drive(mk(1, PCINIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("fetch_pre_ireq_valid", 64'(ireq_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("fetch_rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check("fetch_rst_PCWrite",    64'(PCWrite),    64'd1);
        check("fetch_rst_pc_nxt",     pc_nxt,          PCINIT);
        @(posedge clk);
        #1;

        // Exactly one BOOT cycle after release, then a normal hit.
        vecs.push_back(mk(0, PCINIT, 0, 0, 0, 0, 0, 0, 0,                     0, 2'b01, PCINIT, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT, 0, 0, 0, 1, 64'h80000900, 0, 0,          0, 2'b01, PCINIT, 0, 0, 0));
        vecs.push_back(mk(1, PCINIT, 0, 0, 0, 0, 0, 1, 32'h99,                1, 2'b00, PCINIT + 4, 1, PCINIT, 32'h99));
        run_table("c");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
